// File: rtl/disp_to_value.sv
// Decodes a two-digit multiplexed seven-segment bus back to an 8-bit value after debouncing each digit.
// Capture happens STABLE_CYCLES edges after a new sample. Outputs are registered pulses, and there is no backpressure.
module disp_to_value #(
  parameter int STABLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] seg_in,
  input  logic [1:0] dig_sel,
  output logic [7:0] value_out,
  output logic [1:0] dp_out,
  output logic       valid_out,
  output logic       err_out
);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  state_t     state, state_nxt;
  logic [7:0] r_seg;
  logic [1:0] r_sel;
  logic [3:0] cnt, cnt_nxt;
  logic       chg;
  logic       capture;
  logic [3:0] dec_nib;
  logic       dec_ok;
  logic [3:0] lo_nib, hi_nib;
  logic       lo_dp, hi_dp;
  logic       got_lo, got_hi;

  // Stability is judged on the incoming sample against the registered one.
  // This places the capture exactly STABLE_CYCLES edges after the first sample.
  always_comb begin
    chg     = (seg_in != r_seg) || (dig_sel != r_sel);
    cnt_nxt = cnt;
    if (chg)
      cnt_nxt = 4'd0;
    else if (cnt != 4'hF)
      cnt_nxt = cnt + 4'd1;
  end

  always_comb begin
    dec_ok  = 1'b1;
    dec_nib = 4'h0;
    case (seg_in[6:0])
      7'h3F: dec_nib = 4'h0;
      7'h06: dec_nib = 4'h1;
      7'h5B: dec_nib = 4'h2;
      7'h4F: dec_nib = 4'h3;
      7'h66: dec_nib = 4'h4;
      7'h6D: dec_nib = 4'h5;
      7'h7D: dec_nib = 4'h6;
      7'h07: dec_nib = 4'h7;
      7'h7F: dec_nib = 4'h8;
      7'h6F: dec_nib = 4'h9;
      7'h77: dec_nib = 4'hA;
      7'h7C: dec_nib = 4'hB;
      7'h39: dec_nib = 4'hC;
      7'h5E: dec_nib = 4'hD;
      7'h79: dec_nib = 4'hE;
      7'h71: dec_nib = 4'hF;
      default: dec_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (dig_sel != 2'b00)
          state_nxt = SETTLE;
      end
      SETTLE: begin
        if (dig_sel == 2'b00) begin
          state_nxt = IDLE;
        end else if (!chg && cnt_nxt == 4'(STABLE_CYCLES)) begin
          capture   = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (chg)
          state_nxt = (dig_sel == 2'b00) ? IDLE : SETTLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      r_seg     <= 8'h00;
      r_sel     <= 2'b00;
      cnt       <= 4'd0;
      lo_nib    <= 4'h0;
      hi_nib    <= 4'h0;
      lo_dp     <= 1'b0;
      hi_dp     <= 1'b0;
      got_lo    <= 1'b0;
      got_hi    <= 1'b0;
      value_out <= 8'h00;
      dp_out    <= 2'b00;
      valid_out <= 1'b0;
      err_out   <= 1'b0;
    end else begin
      state     <= state_nxt;
      r_seg     <= seg_in;
      r_sel     <= dig_sel;
      cnt       <= cnt_nxt;
      valid_out <= 1'b0;
      err_out   <= 1'b0;
      if (capture) begin
        if (dig_sel == 2'b11 || !dec_ok) begin
          // A bad digit poisons the whole frame.
          err_out <= 1'b1;
          got_lo  <= 1'b0;
          got_hi  <= 1'b0;
        end else if (dig_sel == 2'b01) begin
          lo_nib <= dec_nib;
          lo_dp  <= seg_in[7];
          if (got_hi) begin
            value_out <= {hi_nib, dec_nib};
            dp_out    <= {hi_dp, seg_in[7]};
            valid_out <= 1'b1;
            got_lo    <= 1'b0;
            got_hi    <= 1'b0;
          end else begin
            got_lo <= 1'b1;
          end
        end else begin
          hi_nib <= dec_nib;
          hi_dp  <= seg_in[7];
          if (got_lo) begin
            value_out <= {dec_nib, lo_nib};
            dp_out    <= {seg_in[7], lo_dp};
            valid_out <= 1'b1;
            got_lo    <= 1'b0;
            got_hi    <= 1'b0;
          end else begin
            got_hi <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_disp_to_value.sv
// Bench for disp_to_value: frame table plus hand sequences, with pulses checked against a scoreboard queue.
module tb_disp_to_value;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] seg_in;
  logic [1:0] dig_sel;
  logic [7:0] value_out;
  logic [1:0] dp_out;
  logic       valid_out;
  logic       err_out;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic       is_err;
    logic [7:0] val;
    logic [1:0] dp;
  } sb_t;

  typedef struct {
    logic [1:0] sel_a;
    logic [7:0] seg_a;
    int         hold_a;
    logic [1:0] sel_b;
    logic [7:0] seg_b;
    int         hold_b;
    bit         exp_err;
    bit         exp_vld;
    logic [7:0] exp_val;
    logic [1:0] exp_dp;
  } vec_t;

  sb_t  sbq[$];
  vec_t tbl[6];

  disp_to_value #(.STABLE_CYCLES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg_in    (seg_in),
    .dig_sel   (dig_sel),
    .value_out (value_out),
    .dp_out    (dp_out),
    .valid_out (valid_out),
    .err_out   (err_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] s, input logic [7:0] g, input int n);
    dig_sel = s;
    seg_in  = g;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_vld(input logic [7:0] v, input logic [1:0] d);
    sb_t e;
    e.is_err = 1'b0;
    e.val    = v;
    e.dp     = d;
    sbq.push_back(e);
  endtask

  task automatic push_err();
    sb_t e;
    e.is_err = 1'b1;
    e.val    = 8'h00;
    e.dp     = 2'b00;
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    if (valid_out || err_out) begin
      sb_t e;
      check("vld_err_exclusive", {31'd0, valid_out & err_out}, 32'd0);
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse valid=%0d err=%0d value=%h dp=%b", valid_out, err_out, value_out, dp_out);
      end else begin
        e = sbq.pop_front();
        check("pulse_kind_err", {31'd0, err_out}, {31'd0, e.is_err});
        if (!e.is_err) begin
          check("value_out", {24'd0, value_out}, {24'd0, e.val});
          check("dp_out", {30'd0, dp_out}, {30'd0, e.dp});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{2'b10, 8'h66, 4,  2'b01, 8'h39, 4, 1'b0, 1'b1, 8'h4C, 2'b00};
    tbl[1] = '{2'b01, 8'h6D, 4,  2'b10, 8'hED, 4, 1'b0, 1'b1, 8'h55, 2'b10};
    tbl[2] = '{2'b01, 8'h7E, 4,  2'b10, 8'h07, 4, 1'b1, 1'b0, 8'h00, 2'b00};
    tbl[3] = '{2'b11, 8'h3F, 4,  2'b10, 8'h66, 20, 1'b1, 1'b0, 8'h00, 2'b00};
    tbl[4] = '{2'b01, 8'h3F, 4,  2'b00, 8'h00, 1, 1'b0, 1'b1, 8'h40, 2'b00};
    tbl[5] = '{2'b01, 8'h5B, 3,  2'b10, 8'hF1, 3, 1'b0, 1'b1, 8'hF2, 2'b10};

    rst_n   = 1'b0;
    seg_in  = 8'h00;
    dig_sel = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_value", {24'd0, value_out}, 32'd0);
    check("rst_dp", {30'd0, dp_out}, 32'd0);
    check("rst_valid", {31'd0, valid_out}, 32'd0);
    check("rst_err", {31'd0, err_out}, 32'd0);
    rst_n = 1'b1;
    drive(2'b00, 8'h00, 2);

    for (int i = 0; i < 6; i++) begin
      if (tbl[i].exp_err) push_err();
      if (tbl[i].exp_vld) push_vld(tbl[i].exp_val, tbl[i].exp_dp);
      drive(tbl[i].sel_a, tbl[i].seg_a, tbl[i].hold_a);
      drive(tbl[i].sel_b, tbl[i].seg_b, tbl[i].hold_b);
      drive(2'b00, 8'h00, 3);
    end

    // One-cycle glitch on 3F must not be captured; only the stable 06 counts.
    push_vld(8'h81, 2'b00);
    drive(2'b01, 8'h3F, 1);
    drive(2'b01, 8'h06, 4);
    drive(2'b10, 8'h7F, 4);
    drive(2'b00, 8'h00, 3);

    // Re-capturing the low digit overwrites it, and the completing digit pulses exactly two edges after it is first sampled.
    drive(2'b01, 8'h06, 4);
    drive(2'b01, 8'h4F, 4);
    push_vld(8'h93, 2'b00);
    dig_sel = 2'b10;
    seg_in  = 8'h6F;
    @(posedge clk);
    @(negedge clk);
    check("latency_edge0", {31'd0, valid_out}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("latency_edge1", {31'd0, valid_out}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("latency_edge2", {31'd0, valid_out}, 32'd1);
    check("latency_value", {24'd0, value_out}, 32'h93);
    @(posedge clk);
    #1;
    drive(2'b00, 8'h00, 3);

    // A mid-frame reset drops the captured high digit.
    drive(2'b10, 8'h79, 4);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_value", {24'd0, value_out}, 32'd0);
    check("midrst_dp", {30'd0, dp_out}, 32'd0);
    rst_n = 1'b1;
    drive(2'b01, 8'h71, 4);
    drive(2'b00, 8'h00, 4);
    check("postrst_value", {24'd0, value_out}, 32'd0);
    check("postrst_dp", {30'd0, dp_out}, 32'd0);
    check("postrst_valid", {31'd0, valid_out}, 32'd0);
    check("postrst_err", {31'd0, err_out}, 32'd0);

    drive(2'b00, 8'h00, 5);
    check("scoreboard_empty", sbq.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
